// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Owns the single write port of the register file. After reset it walks
// x1..x(2^ADDR_WIDTH-1) writing zero, then shares the port between two
// writeback requesters using a valid/ready handshake. All write-port outputs
// are registered and drive RegWrite/WriteReg/WriteData of the register file
// directly.
//
// Parameters
//   DATA_WIDTH     write data width
//   ADDR_WIDTH     register index width (2^ADDR_WIDTH registers)
//   CLEAR_ON_RESET 1: zero-clear sequence after reset, 0: straight to RUN
//   FIXED_PRIORITY 1: Req0 always wins, 0: round-robin
//
// Ports
//   Clock, Reset            rising-edge clock, synchronous active-high reset
//   Req0Valid/Ready/Reg/Data ALU writeback request (Ready is combinational)
//   Req1Valid/Ready/Reg/Data load writeback request (Ready is combinational)
//   RegWrite, WriteReg, WriteData  registered register-file write port
//   Grant                   requester that sourced the current write
//   ClearDone               high while in RUN
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 5,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Req0Valid,
    output logic                  Req0Ready,
    input  logic [ADDR_WIDTH-1:0] Req0Reg,
    input  logic [DATA_WIDTH-1:0] Req0Data,
    input  logic                  Req1Valid,
    output logic                  Req1Ready,
    input  logic [ADDR_WIDTH-1:0] Req1Reg,
    input  logic [DATA_WIDTH-1:0] Req1Data,
    output logic                  RegWrite,
    output logic [ADDR_WIDTH-1:0] WriteReg,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  Grant,
    output logic                  ClearDone
);

    typedef enum logic {CLEAR, RUN} stateType;

    localparam logic [ADDR_WIDTH-1:0] CLR_FIRST = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST  = '1;

    stateType              state;
    stateType              stateNext;
    logic [ADDR_WIDTH-1:0] clr;
    logic [ADDR_WIDTH-1:0] clrNext;
    logic                  last;
    logic                  lastNext;
    logic                  xfer0;
    logic                  xfer1;

    logic                  regWrite_p0;
    logic [ADDR_WIDTH-1:0] writeReg_p0;
    logic [DATA_WIDTH-1:0] writeData_p0;
    logic                  grant_p0;

    // Arbitration. Ready looks only at the Valid lines and arbiter state,
    // never at Reg/Data. Held low while Reset is asserted because the write
    // that handshake would produce is discarded by the reset edge anyway.
    always_comb begin
        Req0Ready = 1'b0;
        Req1Ready = 1'b0;
        if (state == RUN && !Reset) begin
            if (Req0Valid && Req1Valid) begin
                // Round-robin: whoever did not win last time goes now.
                if (FIXED_PRIORITY || last) begin
                    Req0Ready = 1'b1;
                end else begin
                    Req1Ready = 1'b1;
                end
            end else begin
                Req0Ready = Req0Valid;
                Req1Ready = Req1Valid;
            end
        end
    end

    assign xfer0 = Req0Valid && Req0Ready;
    assign xfer1 = Req1Valid && Req1Ready;

    // Next-state and next-output selection (stage p0).
    always_comb begin
        stateNext    = state;
        clrNext      = clr;
        lastNext     = last;
        regWrite_p0  = 1'b0;
        writeReg_p0  = WriteReg;
        writeData_p0 = WriteData;
        grant_p0     = Grant;
        case (state)
            CLEAR: begin
                regWrite_p0  = 1'b1;
                writeReg_p0  = clr;
                writeData_p0 = '0;
                grant_p0     = 1'b0;
                // Leave on the top index instead of incrementing, so clr
                // never wraps back to x0.
                if (clr == CLR_LAST) begin
                    stateNext = RUN;
                end else begin
                    clrNext = clr + CLR_FIRST;
                end
            end
            RUN: begin
                // x0 writes are accepted and counted for fairness, but never
                // reach the register file.
                if (xfer0) begin
                    regWrite_p0  = (Req0Reg != '0);
                    writeReg_p0  = Req0Reg;
                    writeData_p0 = Req0Data;
                    grant_p0     = 1'b0;
                    lastNext     = 1'b0;
                end else if (xfer1) begin
                    regWrite_p0  = (Req1Reg != '0);
                    writeReg_p0  = Req1Reg;
                    writeData_p0 = Req1Data;
                    grant_p0     = 1'b1;
                    lastNext     = 1'b1;
                end
            end
        endcase
    end

    // Stage p0 -> registered write port. last resets to 1 so Req0 wins the
    // first contest after reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr       <= CLR_FIRST;
            last      <= 1'b1;
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            Grant     <= 1'b0;
            ClearDone <= 1'b0;
        end else begin
            state     <= stateNext;
            clr       <= clrNext;
            last      <= lastNext;
            RegWrite  <= regWrite_p0;
            WriteReg  <= writeReg_p0;
            WriteData <= writeData_p0;
            Grant     <= grant_p0;
            ClearDone <= (stateNext == RUN);
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter. Two instances share clock and
// reset: dutA is round-robin, dutF is fixed priority. Expected writes are
// queued when a handshake is driven and matched when the write port fires.
module tb_regfile_write_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;

    typedef struct packed {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
        logic          g;
        logic [31:0]   c;
    } wrT;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          a0Valid = 1'b0, a1Valid = 1'b0;
    logic [AW-1:0] a0Reg = '0, a1Reg = '0;
    logic [DW-1:0] a0Data = '0, a1Data = '0;
    logic          a0Ready, a1Ready, aRegWrite, aGrant, aClearDone;
    logic [AW-1:0] aWriteReg;
    logic [DW-1:0] aWriteData;

    logic          f0Valid = 1'b0, f1Valid = 1'b0;
    logic [AW-1:0] f0Reg = '0, f1Reg = '0;
    logic [DW-1:0] f0Data = '0, f1Data = '0;
    logic          f0Ready, f1Ready, fRegWrite, fGrant, fClearDone;
    logic [AW-1:0] fWriteReg;
    logic [DW-1:0] fWriteData;

    int cyc     = 0;
    int nChecks = 0;
    int nPass   = 0;
    int nFail   = 0;

    wrT qA[$];
    wrT qF[$];

    // Register file model fed by dutA's write port; starts with garbage so
    // the zero-clear is observable.
    logic [DW-1:0] rf [32] = '{default: 64'hDEAD_BEEF_0BAD_F00D};

    regfile_write_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1), .FIXED_PRIORITY(1'b0)
    ) dutA (
        .Clock(clk), .Reset(rst),
        .Req0Valid(a0Valid), .Req0Ready(a0Ready), .Req0Reg(a0Reg), .Req0Data(a0Data),
        .Req1Valid(a1Valid), .Req1Ready(a1Ready), .Req1Reg(a1Reg), .Req1Data(a1Data),
        .RegWrite(aRegWrite), .WriteReg(aWriteReg), .WriteData(aWriteData),
        .Grant(aGrant), .ClearDone(aClearDone)
    );

    regfile_write_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1), .FIXED_PRIORITY(1'b1)
    ) dutF (
        .Clock(clk), .Reset(rst),
        .Req0Valid(f0Valid), .Req0Ready(f0Ready), .Req0Reg(f0Reg), .Req0Data(f0Data),
        .Req1Valid(f1Valid), .Req1Ready(f1Ready), .Req1Reg(f1Reg), .Req1Data(f1Data),
        .RegWrite(fRegWrite), .WriteReg(fWriteReg), .WriteData(fWriteData),
        .Grant(fGrant), .ClearDone(fClearDone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (aRegWrite && aWriteReg != '0) rf[aWriteReg] <= aWriteData;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and match any write on either port against its queue.
    task automatic tick();
        wrT e;
        @(posedge clk);
        @(negedge clk);
        if (aRegWrite !== 1'b0) begin
            if (qA.size() != 0 && qA[0].c == cyc) begin
                e = qA.pop_front();
                chk("a.writeReg", DW'(aWriteReg), DW'(e.r));
                chk("a.writeData", aWriteData, e.d);
                chk("a.grant", DW'(aGrant), DW'(e.g));
            end else begin
                chk("a.unexpectedWrite", DW'(aRegWrite), 64'd0);
            end
        end else if (qA.size() != 0 && qA[0].c == cyc) begin
            e = qA.pop_front();
            chk("a.missingWrite", DW'(aRegWrite), 64'd1);
        end
        if (fRegWrite !== 1'b0) begin
            if (qF.size() != 0 && qF[0].c == cyc) begin
                e = qF.pop_front();
                chk("f.writeReg", DW'(fWriteReg), DW'(e.r));
                chk("f.writeData", fWriteData, e.d);
                chk("f.grant", DW'(fGrant), DW'(e.g));
            end else begin
                chk("f.unexpectedWrite", DW'(fRegWrite), 64'd0);
            end
        end else if (qF.size() != 0 && qF[0].c == cyc) begin
            e = qF.pop_front();
            chk("f.missingWrite", DW'(fRegWrite), 64'd1);
        end
    endtask

    task automatic stepA(input logic v0, input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] r1, input logic [DW-1:0] d1,
                         input logic e0, input logic e1);
        a0Valid = v0; a0Reg = r0; a0Data = d0;
        a1Valid = v1; a1Reg = r1; a1Data = d1;
        #1;
        chk("a.req0Ready", DW'(a0Ready), DW'(e0));
        chk("a.req1Ready", DW'(a1Ready), DW'(e1));
        chk("a.oneReady", DW'(a0Ready & a1Ready), 64'd0);
        if (e0 && r0 != '0) qA.push_back('{r: r0, d: d0, g: 1'b0, c: 32'(cyc + 1)});
        if (e1 && r1 != '0) qA.push_back('{r: r1, d: d1, g: 1'b1, c: 32'(cyc + 1)});
        tick();
    endtask

    task automatic stepF(input logic v0, input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] r1, input logic [DW-1:0] d1,
                         input logic e0, input logic e1);
        f0Valid = v0; f0Reg = r0; f0Data = d0;
        f1Valid = v1; f1Reg = r1; f1Data = d1;
        #1;
        chk("f.req0Ready", DW'(f0Ready), DW'(e0));
        chk("f.req1Ready", DW'(f1Ready), DW'(e1));
        chk("f.oneReady", DW'(f0Ready & f1Ready), 64'd0);
        if (e0 && r0 != '0) qF.push_back('{r: r0, d: d0, g: 1'b0, c: 32'(cyc + 1)});
        if (e1 && r1 != '0) qF.push_back('{r: r1, d: d1, g: 1'b1, c: 32'(cyc + 1)});
        tick();
    endtask

    // Hold reset for n edges; any pending expected writes are abandoned.
    task automatic doReset(input int n);
        rst = 1'b1;
        qA.delete();
        qF.delete();
        for (int i = 0; i < n; i++) begin
            tick();
            chk("a.rstRegWrite", DW'(aRegWrite), 64'd0);
            chk("a.rstWriteReg", DW'(aWriteReg), 64'd0);
            chk("a.rstWriteData", aWriteData, 64'd0);
            chk("a.rstGrant", DW'(aGrant), 64'd0);
            chk("a.rstClearDone", DW'(aClearDone), 64'd0);
            chk("f.rstRegWrite", DW'(fRegWrite), 64'd0);
            chk("f.rstClearDone", DW'(fClearDone), 64'd0);
        end
    endtask

    // Release reset and follow the first n clear cycles; requesters are
    // valid throughout and must never see Ready.
    task automatic runClear(input int n);
        int base;
        rst  = 1'b0;
        base = cyc;
        for (int i = 1; i <= 31; i++) begin
            qA.push_back('{r: AW'(i), d: '0, g: 1'b0, c: 32'(base + i)});
            qF.push_back('{r: AW'(i), d: '0, g: 1'b0, c: 32'(base + i)});
        end
        a0Valid = 1'b1; a0Reg = 5'd3; a0Data = 64'h33;
        a1Valid = 1'b1; a1Reg = 5'd4; a1Data = 64'h44;
        f0Valid = 1'b1; f0Reg = 5'd3; f0Data = 64'h33;
        f1Valid = 1'b1; f1Reg = 5'd4; f1Data = 64'h44;
        for (int i = 1; i <= n; i++) begin
            #1;
            chk("a.clrReady0", DW'(a0Ready), 64'd0);
            chk("a.clrReady1", DW'(a1Ready), 64'd0);
            chk("f.clrReady0", DW'(f0Ready), 64'd0);
            chk("f.clrReady1", DW'(f1Ready), 64'd0);
            tick();
            chk("a.clearDone", DW'(aClearDone), DW'(i == 31));
            chk("f.clearDone", DW'(fClearDone), DW'(i == 31));
        end
        a0Valid = 1'b0; a1Valid = 1'b0;
        f0Valid = 1'b0; f1Valid = 1'b0;
    endtask

    initial begin
        // Reset and full zero-clear.
        doReset(2);
        runClear(31);
        tick();
        for (int r = 1; r < 32; r++) chk($sformatf("rf.clear.x%0d", r), rf[r], 64'd0);

        // Round-robin contention: last=1 after reset, so Req0 goes first.
        stepA(1'b1, 5'd6, 64'd60, 1'b1, 5'd7, 64'd70, 1'b1, 1'b0);
        stepA(1'b1, 5'd6, 64'd61, 1'b1, 5'd7, 64'd70, 1'b0, 1'b1);
        stepA(1'b1, 5'd6, 64'd61, 1'b1, 5'd7, 64'd71, 1'b1, 1'b0);
        stepA(1'b1, 5'd6, 64'd62, 1'b1, 5'd7, 64'd71, 1'b0, 1'b1);
        stepA(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
        chk("rf.x6", rf[6], 64'd61);
        chk("rf.x7", rf[7], 64'd71);

        // Single requester.
        stepA(1'b1, 5'd5, 64'd105, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0);
        stepA(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
        chk("rf.x5", rf[5], 64'd105);

        // x0 write from Req1: accepted, no RegWrite, and it counts as Req1's turn.
        stepA(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFFFF, 1'b0, 1'b1);
        chk("a.x0RegWrite", DW'(aRegWrite), 64'd0);
        stepA(1'b1, 5'd8, 64'd80, 1'b1, 5'd9, 64'd90, 1'b1, 1'b0);
        stepA(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'd90, 1'b0, 1'b1);
        stepA(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
        // Idle cycle: enable drops, the rest of the port holds.
        chk("a.idleRegWrite", DW'(aRegWrite), 64'd0);
        chk("a.holdWriteReg", DW'(aWriteReg), 64'd9);
        chk("a.holdWriteData", aWriteData, 64'd90);
        chk("a.holdGrant", DW'(aGrant), 64'd1);

        // Fixed priority: Req1 waits until Req0 drops.
        stepF(1'b1, 5'd10, 64'd100, 1'b1, 5'd11, 64'd110, 1'b1, 1'b0);
        stepF(1'b1, 5'd10, 64'd101, 1'b1, 5'd11, 64'd110, 1'b1, 1'b0);
        stepF(1'b1, 5'd10, 64'd102, 1'b1, 5'd11, 64'd110, 1'b1, 1'b0);
        stepF(1'b0, 5'd0, 64'd0, 1'b1, 5'd11, 64'd110, 1'b0, 1'b1);
        stepF(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);

        // Reset at clear cycle 10, then a clean clear from x1.
        doReset(2);
        runClear(9);
        doReset(1);
        runClear(31);

        // Reset the cycle after a Req0 handshake, with another request pending.
        stepA(1'b1, 5'd5, 64'd205, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0);
        a0Valid = 1'b1; a0Reg = 5'd12; a0Data = 64'hC;
        doReset(1);
        runClear(31);
        tick();
        chk("rf.x5.recleared", rf[5], 64'd0);
        chk("rf.x12.recleared", rf[12], 64'd0);

        // last was 0 before reset; reset must hand the first contest to Req0.
        stepA(1'b1, 5'd13, 64'd130, 1'b1, 5'd14, 64'd140, 1'b1, 1'b0);
        stepA(1'b0, 5'd0, 64'd0, 1'b1, 5'd14, 64'd140, 1'b0, 1'b1);
        stepA(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
        chk("rf.x13", rf[13], 64'd130);
        chk("a.queueDrained", DW'(qA.size()), 64'd0);
        chk("f.queueDrained", DW'(qF.size()), 64'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Sequencer and arbiter for the single write port of `RegisterFile` (32 x 64-bit, x0 hardwired to zero). After reset it zero-clears x1..x31 through the write port. It then shares that port between two writeback requesters (Req0 = ALU writeback, Req1 = memory/load writeback) using a valid/ready handshake. Its registered outputs connect directly to `RegWrite`, `WriteReg` and `WriteData` of the register file.

## Interface
- `DATA_WIDTH`, 64, width of write data.
- `ADDR_WIDTH`, 5, register index width; the register count is 2^ADDR_WIDTH.
- `CLEAR_ON_RESET`, 1, 1 = run the zero-clear sequence after reset; 0 = enter RUN directly.
- `FIXED_PRIORITY`, 0, 0 = round-robin; 1 = Req0 always wins.
- `Clock` input 1: the single clock; all state updates on the rising edge.
- `Reset` input 1: synchronous, active-high.
- `Req0Valid` input 1: Req0 has a write pending.
- `Req0Ready` output 1: Req0 is accepted this cycle (combinational).
- `Req0Reg` input ADDR_WIDTH: destination register for Req0.
- `Req0Data` input DATA_WIDTH: write data for Req0.
- `Req1Valid`, `Req1Ready`, `Req1Reg`, `Req1Data`: same as the Req0 ports, for Req1.
- `RegWrite` output 1: registered write enable to the register file.
- `WriteReg` output ADDR_WIDTH: registered write index.
- `WriteData` output DATA_WIDTH: registered write data.
- `Grant` output 1: registered; the requester that sourced the current write (0 during CLEAR).
- `ClearDone` output 1: registered; high while in the RUN state.

## Operation
- States: CLEAR and RUN. `Reset` selects CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
- **CLEAR**
  - Internal counter `clr` is set to 1 by reset.
  - Each edge in CLEAR loads the outputs with RegWrite=1, WriteReg=clr, WriteData=0, Grant=0, then increments clr.
  - The edge that loads clr = 2^ADDR_WIDTH-1 also moves the state to RUN.
  - Both Ready outputs are 0 throughout CLEAR.
- **RUN, arbitration** (combinational)
  - Only Req0Valid: Req0Ready=1.
  - Only Req1Valid: Req1Ready=1.
  - Both valid, FIXED_PRIORITY=1: Req0 wins.
  - Both valid, FIXED_PRIORITY=0: the requester not equal to `last` wins.
  - At most one Ready is high per cycle.
  - Ready never depends on the requester's own Reg or Data.
- **Transfer**: a transfer occurs when Valid && Ready. At that edge:
  - the outputs load RegWrite=1, WriteReg=ReqNReg, WriteData=ReqNData, Grant=N;
  - `last` updates to N on every transfer, contested or not.
- **x0 writes**: a request with Reg=0 is accepted (Ready high, transfer counted, `last` updated), but RegWrite loads 0.
- **No transfer** in a RUN cycle: RegWrite loads 0. WriteReg, WriteData and Grant hold their previous values.
- Requesters must hold Reg and Data stable while Valid is high and Ready is low.
- Same destination from both requesters in consecutive cycles: writes issue in grant order; the later grant wins in the register file.
- No backpressure from the register file; one write is issued per cycle at most.

## Timing
- **Reset edge** (any state, including mid-CLEAR or with a transfer in flight):
  - RegWrite=0, WriteReg=0, WriteData=0, Grant=0, ClearDone=0, last=1 (so Req0 wins the first contest);
  - the in-flight output write is dropped;
  - clr=1 and the state is re-entered per CLEAR_ON_RESET.
  - With CLEAR_ON_RESET=0, ClearDone=1 from the first edge after Reset deasserts.
- **CLEAR sequence**, first edge with Reset low = cycle 1:
  - cycles 1..31 present writes to x1..x31, with RegWrite high for 31 consecutive cycles;
  - ClearDone=1 from cycle 31 onward;
  - Ready is first possible during cycle 31, so the first request write appears at cycle 32.
- **Latency**: 1 cycle from handshake edge to RegWrite on the outputs. The register file commits on the following edge, 2 edges after the handshake.
- **Throughput**: one accepted request per cycle, sustained. With both requesters continuously valid and round-robin, grants alternate every cycle.
- **Counter width**: clr is ADDR_WIDTH bits and never wraps; CLEAR exits before overflow.

## Test plan
- **Reset clear**: Reset high for 2 cycles, then low, no requests.
  - RegWrite=1 for exactly 31 cycles with WriteReg 1..31 and WriteData=0.
  - ClearDone rises with the x31 write; afterwards reading x5 returns 0.
- **Single requester**: after ClearDone, Req0 writes x5=105 for one cycle.
  - Req0Ready=1 that cycle; the next cycle shows RegWrite=1, WriteReg=5, WriteData=105, Grant=0.
  - Register file read of x5 returns 105.
- **Round-robin contention**: Req0 and Req1 both valid for 4 cycles, Req0→x6, Req1→x7.
  - Grants are 0,1,0,1; x6 and x7 hold their data; never both Ready high in one cycle.
- **Fixed priority**: FIXED_PRIORITY=1, both requesters valid for 3 cycles.
  - Req1Ready stays 0; Req1 is granted the cycle after Req0Valid drops.
- **x0 drop**: Req1 writes x0=64'hFFFF.
  - Req1Ready=1, RegWrite=0 the next cycle, x0 reads 0.
  - The next contested cycle grants Req0.
- **Mid-operation reset**: assert Reset at clear cycle 10, then again the cycle after a Req0 handshake in RUN.
  - Each time RegWrite=0 on the following edge, the clear restarts at x1, and ClearDone drops to 0.
